// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard and its match units.
package hazard_pkg;

    // Widest register address a scoreboard entry can hold; REG_AW is checked against it.
    localparam int MAX_AW = 8;

    // Operand select value meaning "take the register file read".
    localparam int FWD_RF = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              rw;
        logic              md;
    } sb_entry_t;

    // Bits needed to encode 0..n; never less than one so degenerate sizes stay legal.
    function automatic int selw(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Youngest-match priority encoder for one source operand against all scoreboard entries.
module sb_match
    import hazard_pkg::*;
#(
    parameter  int DEPTH  = 3,
    parameter  int REG_AW = 5,
    localparam int IDXW   = selw(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [REG_AW-1:0]     src,
    output logic                  hit,
    output logic [IDXW-1:0]       idx,
    output logic                  is_load
);

    // Scan oldest to youngest so the lowest matching index wins; x0 never matches.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].rw && (entries[k].rd != '0) &&
                (entries[k].rd == MAX_AW'(src))) begin
                hit     = 1'b1;
                idx     = IDXW'(k);
                is_load = entries[k].md;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: operand forwarding selects, load-use stall and redirect flush.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int XLEN        = 32,
    parameter  int REG_AW      = 5,
    parameter  int DEPTH       = 3,
    parameter  int NSRC        = 2,
    parameter  int LOAD_LAT    = 2,
    parameter  int FLUSH_DEPTH = 2,
    localparam int SELW        = selw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_rw,
    input  logic                   id_md,
    input  logic                   ex_redirect,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   flush,
    output logic [15:0]            stall_cnt
);

    localparam int              FCW        = selw(FLUSH_DEPTH);
    localparam logic [SELW-1:0] LOAD_LAT_S = SELW'(LOAD_LAT);
    localparam logic [FCW-1:0]  FLUSH_INIT = FCW'(FLUSH_DEPTH);

    // Reject parameter sets the encoders and counters are not sized for.
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("hazard_scoreboard: DEPTH must be 1..8");
    end
    if (LOAD_LAT < 0 || LOAD_LAT > DEPTH - 1) begin : g_bad_load_lat
        $error("hazard_scoreboard: LOAD_LAT must be 0..DEPTH-1");
    end
    if (REG_AW < 1 || REG_AW > MAX_AW) begin : g_bad_reg_aw
        $error("hazard_scoreboard: REG_AW out of range");
    end
    if (NSRC < 1 || FLUSH_DEPTH < 0 || XLEN < 1) begin : g_bad_misc
        $error("hazard_scoreboard: NSRC, FLUSH_DEPTH or XLEN out of range");
    end

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]            hit;
    logic [NSRC-1:0]            is_load;
    logic [NSRC-1:0]            load_use;
    logic [NSRC-1:0][SELW-1:0]  idx;

    // One match unit per source; a load is only usable once it reaches LOAD_LAT.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        sb_match #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW)
        ) u_match (
            .entries (sb_q),
            .src     (id_rs[s*REG_AW +: REG_AW]),
            .hit     (hit[s]),
            .idx     (idx[s]),
            .is_load (is_load[s])
        );
        assign fwd_sel[s*SELW +: SELW] = hit[s] ? (idx[s] + SELW'(1)) : SELW'(FWD_RF);
        assign load_use[s]             = hit[s] & is_load[s] & (idx[s] < LOAD_LAT_S);
    end

    // Flush wins over stall; flush is forced low while reset is held.
    always_comb begin
        flush = reset & (ex_redirect | (fcnt_q != '0));
        stall = id_valid & ~flush & (|load_use);
    end

    // Next state: shift the scoreboard, reload or drain the flush counter, count stalls.
    always_comb begin
        sb_d = '0;
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (id_valid && !stall && !flush) begin
            sb_d[0].valid = 1'b1;
            sb_d[0].rd    = MAX_AW'(id_rd);
            sb_d[0].rw    = id_rw;
            sb_d[0].md    = id_md;
        end

        fcnt_d = fcnt_q;
        if (ex_redirect) begin
            fcnt_d = FLUSH_INIT;
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FCW'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers, cleared asynchronously so outputs fall the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q        <= '0;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a cycle-history reference model.
module tb_hazard_scoreboard;

    localparam int XLEN        = 32;
    localparam int REG_AW      = 5;
    localparam int DEPTH       = 3;
    localparam int NSRC        = 2;
    localparam int LOAD_LAT    = 2;
    localparam int FLUSH_DEPTH = 2;
    localparam int SELW        = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   id_valid = 1'b0;
    logic [NSRC*REG_AW-1:0] id_rs = '0;
    logic [REG_AW-1:0]      id_rd = '0;
    logic                   id_rw = 1'b0;
    logic                   id_md = 1'b0;
    logic                   ex_redirect = 1'b0;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   stall;
    logic                   flush;
    logic [15:0]            stall_cnt;

    hazard_scoreboard #(
        .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC),
        .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_rw(id_rw), .id_md(id_md), .ex_redirect(ex_redirect),
        .fwd_sel(fwd_sel), .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what was accepted into EX at each cycle; stage k now holds cycle cyc-1-k.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit md;
    } ins_t;

    ins_t issued[0:4095];
    int   cyc = 0;
    int   base = 0;
    int   last_redir = -100;
    int   m_scnt = 0;
    bit   m_stall = 1'b0;
    bit   m_flush = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs0, input int rs1, input int rd,
                         input bit rw, input bit md, input bit redir);
        id_valid    = v;
        id_rs       = {REG_AW'(rs1), REG_AW'(rs0)};
        id_rd       = REG_AW'(rd);
        id_rw       = rw;
        id_md       = md;
        ex_redirect = redir;
        #1;
    endtask

    task automatic model_check(input string tag);
        logic [NSRC*SELW-1:0] esel;
        bit lu;
        int found;
        int src;
        int at;
        esel = '0;
        lu   = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            src   = int'(id_rs[s*REG_AW +: REG_AW]);
            found = -1;
            for (int k = 0; k < DEPTH; k++) begin
                at = cyc - 1 - k;
                if (found < 0 && at >= base && issued[at].v && issued[at].rw &&
                    issued[at].rd != 0 && issued[at].rd == src)
                    found = k;
            end
            if (found >= 0) begin
                esel[s*SELW +: SELW] = SELW'(found + 1);
                if (issued[cyc-1-found].md && found < LOAD_LAT) lu = 1'b1;
            end
        end
        m_flush = ex_redirect || (cyc - last_redir <= FLUSH_DEPTH);
        m_stall = id_valid && !m_flush && lu;
        chk({tag, ".fwd"},   32'(fwd_sel), 32'(esel));
        chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
        chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
        chk({tag, ".scnt"},  32'(stall_cnt), 32'(m_scnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (id_valid && !m_stall && !m_flush) begin
            issued[cyc].v  = 1'b1;
            issued[cyc].rd = int'(id_rd);
            issued[cyc].rw = id_rw;
            issued[cyc].md = id_md;
        end else begin
            issued[cyc].v  = 1'b0;
            issued[cyc].rd = 0;
            issued[cyc].rw = 1'b0;
            issued[cyc].md = 1'b0;
        end
        if (m_stall && m_scnt < 65535) m_scnt++;
        if (ex_redirect) last_redir = cyc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic step(input string tag, input bit v, input int rs0, input int rs1, input int rd,
                        input bit rw, input bit md, input bit redir);
        drive(v, rs0, rs1, rd, rw, md, redir);
        model_check(tag);
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.fwd", 32'(fwd_sel), 0);
        chk("rst.stall", 32'(stall), 0);
        chk("rst.flush", 32'(flush), 0);
        chk("rst.scnt", 32'(stall_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Forwarding from EX, MEM, WB, then retired
        step("fw0", 1, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0); model_check("fw1"); chk("fw.ex",  32'(fwd_sel[SELW-1:0]), 1); tick();
        drive(1, 5, 0, 0, 0, 0, 0); model_check("fw2"); chk("fw.mem", 32'(fwd_sel[SELW-1:0]), 2); tick();
        drive(1, 5, 0, 0, 0, 0, 0); model_check("fw3"); chk("fw.wb",  32'(fwd_sel[SELW-1:0]), 3); tick();
        drive(1, 5, 0, 0, 0, 0, 0); model_check("fw4"); chk("fw.ret", 32'(fwd_sel[SELW-1:0]), 0); tick();

        // Load-use: two stall cycles, then forward from stage 2
        step("lu0", 1, 0, 0, 7, 1, 1, 0);
        drive(1, 0, 7, 0, 0, 0, 0); model_check("lu1"); chk("lu.stall1", 32'(stall), 1); tick();
        drive(1, 0, 7, 0, 0, 0, 0); model_check("lu2"); chk("lu.stall2", 32'(stall), 1); tick();
        drive(1, 0, 7, 0, 0, 0, 0); model_check("lu3");
        chk("lu.release", 32'(stall), 0);
        chk("lu.fwd",     32'(fwd_sel[2*SELW-1:SELW]), 3);
        chk("lu.scnt",    32'(stall_cnt), 2);
        tick();

        // Zero register never forwards or stalls
        step("x0w", 1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); model_check("x0r");
            chk("x0.fwd", 32'(fwd_sel), 0);
            chk("x0.stall", 32'(stall), 0);
            tick();
        end

        // Redirect: flush window, bubbles in EX, older entries keep forwarding, reload
        step("rd0", 1, 0, 0, 9, 1, 0, 0);
        step("rd1", 1, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 10, 10, 1, 0, 1); model_check("rdA");
        chk("rd.flush0", 32'(flush), 1); chk("rd.fwdmem", 32'(fwd_sel[SELW-1:0]), 2); tick();
        drive(1, 9, 10, 10, 1, 0, 0); model_check("rdB");
        chk("rd.flush1", 32'(flush), 1); chk("rd.fwdwb", 32'(fwd_sel[SELW-1:0]), 3);
        chk("rd.bubble", 32'(fwd_sel[2*SELW-1:SELW]), 0); tick();
        drive(1, 0, 10, 10, 1, 0, 1); model_check("rdC"); chk("rd.flush2", 32'(flush), 1); tick();
        drive(1, 0, 10, 10, 1, 0, 0); model_check("rdD"); chk("rd.reload1", 32'(flush), 1); tick();
        drive(1, 0, 10, 10, 1, 0, 0); model_check("rdE"); chk("rd.reload2", 32'(flush), 1); tick();
        drive(1, 0, 10, 10, 1, 0, 0); model_check("rdF"); chk("rd.done", 32'(flush), 0); tick();

        // Redirect collides with load-use: redirect wins, no stall counted
        step("co0", 1, 0, 0, 7, 1, 1, 0);
        drive(1, 0, 7, 0, 0, 0, 1); model_check("co1");
        chk("co.stall", 32'(stall), 0); chk("co.flush", 32'(flush), 1);
        chk("co.scnt", 32'(stall_cnt), 2); tick();
        step("co2", 1, 0, 7, 0, 0, 0, 0);
        step("co3", 1, 0, 7, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0); model_check("co4"); chk("co.scnt2", 32'(stall_cnt), 2); tick();

        // Reset asserted in the middle of a stall
        step("rs0", 1, 0, 0, 12, 1, 1, 0);
        drive(1, 12, 0, 0, 0, 0, 0); model_check("rs1"); chk("rs.stall", 32'(stall), 1);
        reset = 1'b0;
        #1;
        chk("rs.stall0", 32'(stall), 0);
        chk("rs.flush0", 32'(flush), 0);
        chk("rs.fwd0",   32'(fwd_sel), 0);
        chk("rs.scnt0",  32'(stall_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        base       = cyc;
        last_redir = -100;
        m_scnt     = 0;
        drive(1, 12, 0, 0, 0, 0, 0); model_check("rs2");
        chk("rs.empty", 32'(stall), 0); chk("rs.scnt", 32'(stall_cnt), 0); tick();

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: datapath width, carried for package consistency only.
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 Parameter DEPTH, default 3: tracked post-decode stages (0=EX, 1=MEM, 2=WB).
REQ-004 Parameter NSRC, default 2: source operands checked per decoded instruction.
REQ-005 Parameter LOAD_LAT, default 2: load data is forwardable only from stage index >= LOAD_LAT.
REQ-006 Parameter FLUSH_DEPTH, default 2: cycles the flush outputs stay asserted after a redirect.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 id_valid  in  1  decode stage holds a real instruction.
REQ-010 id_rs  in  NSRC*REG_AW  packed source addresses; source s occupies bits [s*REG_AW +: REG_AW].
REQ-011 id_rd  in  REG_AW  destination of the decoded instruction.
REQ-012 id_rw  in  1  decoded instruction writes the register file.
REQ-013 id_md  in  1  decoded instruction is a load.
REQ-014 ex_redirect  in  1  branch or jump resolved taken in EX this cycle.
REQ-015 fwd_sel  out  NSRC*SELW  per-source operand select (SELW = clog2(DEPTH+1)): 0 = register file, k+1 = stage k result.
REQ-016 stall  out  1  hold PC and IF/ID, inject bubble into EX.
REQ-017 flush  out  1  invalidate IF/ID and ID/EX contents.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Scoreboard: DEPTH entries {valid, rd, rw, md}; all entries shift one stage per cycle, and entry DEPTH-1 retires.
REQ-020 Stage-0 load: when id_valid=1, stall=0 and flush=0, load stage 0 with {1, id_rd, id_rw, id_md}; otherwise load stage 0 with valid=0 (bubble).
REQ-021 Match rule: entry k matches source s when valid=1, rw=1, rd!=0 and rd equals source s.
REQ-022 Forward select (combinational, zero latency): fwd_sel[s] = k+1 for the lowest-index (youngest) matching k; 0 when no entry matches or source s is 0.
REQ-023 Load-use stall (combinational): stall=1 when, for any s, the youngest matching entry has md=1 and k < LOAD_LAT; an older non-load match never masks a younger load.
REQ-024 Stall qualification: stall is gated by id_valid=1 and flush=0.
REQ-025 Repeated stalls: stall repeats each cycle until the load reaches stage LOAD_LAT; at that point fwd_sel selects it and stall drops the same cycle.
REQ-026 Redirect: ex_redirect=1 loads the flush counter with FLUSH_DEPTH, regardless of its current value.
REQ-027 Flush output: flush = ex_redirect OR (counter != 0); the counter decrements each cycle while nonzero.
REQ-028 Flush effect on scoreboard: while flush=1, stage 0 receives bubbles; entries already in stages >= 1 are unaffected.
REQ-029 Simultaneous redirect and load-use: redirect wins; stall=0 that cycle.
REQ-030 Stall counter: stall_cnt increments by 1 on each cycle with stall=1 and holds at 16'hFFFF.

Reset
REQ-031 While reset=0: all entry valid bits are 0, the flush counter is 0 and stall_cnt is 0, so fwd_sel=0, stall=0 and flush=0 asynchronously.
REQ-032 Reset mid-operation: any in-flight stall or flush is discarded; the first cycle after release behaves as an empty pipeline.

Structure
REQ-033 Shared package hazard_pkg: the SELW function, the scoreboard-entry struct and the FWD_RF=0 constant; the top-level pipeline imports the same package.
REQ-034 One sub-module, sb_match, instantiated NSRC times: combinational youngest-match priority encoder producing {hit, idx, is_load}.
REQ-035 Parameter limits: DEPTH ranges 1..8 and LOAD_LAT ranges 0..DEPTH-1; other values are rejected at elaboration.

Verification
REQ-036 Forwarding: ALU write to x5, then a dependent instruction next cycle with rs1=x5 -> fwd_sel[0]=1; one cycle later -> 2; after retire -> 0.
REQ-037 Load-use: load x7 followed by an instruction reading rs2=x7, LOAD_LAT=2 -> stall=1 for exactly 2 cycles, then fwd_sel[1]=3, stall=0, stall_cnt=2.
REQ-038 Zero register: id_rd=0, id_rw=1, then a read of x0 -> fwd_sel=0 and stall=0 at every stage.
REQ-039 Redirect: ex_redirect pulse with FLUSH_DEPTH=2 -> flush=1 for 3 consecutive cycles (pulse plus 2), stage 0 holds bubbles, older entries still forward; a second redirect during the flush reloads the counter to 2.
REQ-040 Collision: redirect in the same cycle as a load-use hazard -> stall=0, flush=1, stall_cnt unchanged.
REQ-041 Reset: assert reset=0 mid-stall -> stall, flush and fwd_sel go to 0 immediately; stall_cnt=0 after release.
